ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline, directly downstream of the ALU forwarding unit.
- Consumes ForwardA/ForwardB selects and picks ALU operands from the register file, the EX/MEM result or the MEM/WB writeback data.
- Computes the ALU result, including an optional iterative multiply.
- Owns the EX/MEM pipeline register, with stall, flush and bubble insertion.

Parameters:
- XLEN, 32, datapath width.
- MUL_CYCLES, 32, shift-add iterations for MUL; must equal XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall_in  in  1  downstream stall; hold EX/MEM.
- flush_in  in  1  kill the instruction in EX; next EX/MEM is a bubble.
- id_ex_valid  in  1  ID/EX holds a real instruction.
- id_ex_rs1_data  in  XLEN  register-file rs1 value.
- id_ex_rs2_data  in  XLEN  register-file rs2 value.
- id_ex_imm  in  XLEN  sign-extended immediate.
- id_ex_alu_op  in  4  ALU operation (package encoding).
- id_ex_alu_src  in  1  1 = operand B is the immediate.
- id_ex_rd  in  5  destination register.
- id_ex_regwrite  in  1  control bit, passed through to EX/MEM.
- id_ex_memtoreg  in  1  control bit, passed through to EX/MEM.
- id_ex_memwrite  in  1  control bit, passed through to EX/MEM.
- forward_a  in  2  operand A select from the forwarding unit.
- forward_b  in  2  operand B select from the forwarding unit.
- mem_wb_data  in  XLEN  MEM/WB writeback value (ALU result or load data).
- ex_busy  out  1  multi-cycle op in progress; upstream must hold ID/EX.
- ex_mem_valid  out  1  EX/MEM holds a real instruction.
- ex_mem_alu_result  out  XLEN  registered ALU result; also the forward source for select 10.
- ex_mem_store_data  out  XLEN  forwarded rs2 value, used by stores.
- ex_mem_rd  out  5  registered destination register.
- ex_mem_regwrite  out  1  registered control bit.
- ex_mem_memtoreg  out  1  registered control bit.
- ex_mem_memwrite  out  1  registered control bit.

Behaviour:
- Reset: every ex_mem_* output is 0, ex_busy is 0, FSM is IDLE, iteration counter is 0. Reset takes priority over everything.
- Forward mux, per operand:
  - 00: register-file value.
  - 10: ex_mem_alu_result.
  - 01: mem_wb_data.
  - 11: treated as 00.
- Operand B: the immediate when alu_src = 1, otherwise the forwarded rs2 value. Store data is always the forwarded rs2 value.
- ALU ops:
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4.
  - SLL 5, SRL 6, SRA 7; shift amount is B[4:0].
  - SLT 8 (signed), SLTU 9 (unsigned); both produce 0 or 1.
  - PASSB 10.
  - MUL 11 (optional feature).
  - Codes 12-15 produce result 0.
  - All arithmetic is modulo 2^XLEN.
- Single-cycle ops: the result is registered into EX/MEM on the next clk edge (latency 1).
- Update priority each edge: reset > flush_in > stall_in > normal.
  - Flush: load a bubble (valid = 0, regwrite = 0, memwrite = 0; other fields 0).
  - Stall: hold every EX/MEM field.
  - Normal: when id_ex_valid = 0, load a bubble.
- FSM (MUL only): IDLE -> BUSY -> DONE -> IDLE.
  - IDLE with a valid MUL and no flush: ex_busy = 1 combinationally; latch both forwarded operands; EX/MEM gets a bubble; go to BUSY with counter 0.
  - BUSY: one shift-add step per cycle; ex_busy = 1; EX/MEM gets a bubble; after the step with counter = MUL_CYCLES-1, go to DONE.
  - DONE: ex_busy = 0; the low XLEN bits of the product load into EX/MEM with the normal controls, then go to IDLE. If stall_in is high, stay in DONE.
  - Result: 34 cycles in EX, 33 bubbles, then the result.
  - Latched operands are not affected by later changes on the forward selects or mem_wb_data.
  - flush_in in BUSY or DONE aborts: go to IDLE, ex_busy = 0, no result written.
  - Downstream stall_in during BUSY does not pause iteration.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: MUL op 11 and the FSM as described.
- Undefined: op 11 produces result 0 with latency 1; ex_busy is tied to 0; no FSM or multiplier logic is built.

Decomposition:
- Package ex_pkg holds:
  - XLEN default;
  - ALU op codes;
  - forward select constants FWD_NONE = 00, FWD_EX_MEM = 10, FWD_MEM_WB = 01;
  - FSM state encoding.
- Sub-module mul_iter: iterative shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done, product.
  - Instantiated only under EX_MUL_EN.

Test Plan:
- Reset is held for 2 cycles, then id_ex_valid = 1, ADD 5 + 7 -> all ex_mem_* outputs read 0 during reset; ex_mem_alu_result = 12 and valid = 1 one edge later.
- forward_a = 10 with ex_mem_alu_result = 100, rs1 = 1, rs2 = 3, SUB -> result 97. Repeat with forward_a = 01 and mem_wb_data = 50 -> result 47.
- SRA with A = 0x80000000, B = 4 -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT gives 0 for the same pair.
- MUL 6 × 7 with EX_MUL_EN defined -> ex_busy = 1 for 33 cycles, 33 bubbles, then result 42 with valid = 1. Changing mem_wb_data mid-operation does not change the result.
- flush_in asserted at BUSY iteration 10 -> FSM returns to IDLE, ex_busy = 0, EX/MEM holds a bubble, and the next ADD completes normally.
- stall_in held 3 cycles with a valid ADD (1 + 1) -> EX/MEM keeps its prior value; the result 2 appears on the edge after stall_in drops. When flush_in and stall_in are high together, a bubble is loaded.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: widths, ALU codes, forward selects.
// FSM encoding is only used when EX_MUL_EN is defined.
package ex_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
// done is high during the final step; product is valid the cycle after.
module mul_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(MUL_CYCLES);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   cnt;
  logic            run;

  assign done    = run && (cnt == CW'(MUL_CYCLES - 1));
  assign product = acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      if (mplier[0])
        acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM register.
// Define EX_MUL_EN to build the iterative MUL (op 11) and its FSM.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            id_ex_valid,
  input  logic [XLEN-1:0] id_ex_rs1_data,
  input  logic [XLEN-1:0] id_ex_rs2_data,
  input  logic [XLEN-1:0] id_ex_imm,
  input  logic [3:0]      id_ex_alu_op,
  input  logic            id_ex_alu_src,
  input  logic [4:0]      id_ex_rd,
  input  logic            id_ex_regwrite,
  input  logic            id_ex_memtoreg,
  input  logic            id_ex_memwrite,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            ex_busy,
  output logic            ex_mem_valid,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_store_data,
  output logic [4:0]      ex_mem_rd,
  output logic            ex_mem_regwrite,
  output logic            ex_mem_memtoreg,
  output logic            ex_mem_memwrite
);

  if (MUL_CYCLES != XLEN) begin : g_cfg_err
    $error("MUL_CYCLES must equal XLEN");
  end

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] sd;
    logic [4:0]      rd;
    logic            rw;
    logic            mtr;
    logic            mw;
  } ex_mem_t;

  ex_mem_t         r;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] wb_res;
  logic            hold_bubble;

  always_comb begin
    op_a = id_ex_rs1_data;
    unique case (forward_a)
      FWD_EX_MEM: op_a = r.res;
      FWD_MEM_WB: op_a = mem_wb_data;
      default:    op_a = id_ex_rs1_data;
    endcase
  end

  always_comb begin
    rs2_fwd = id_ex_rs2_data;
    unique case (forward_b)
      FWD_EX_MEM: rs2_fwd = r.res;
      FWD_MEM_WB: rs2_fwd = mem_wb_data;
      default:    rs2_fwd = id_ex_rs2_data;
    endcase
  end

  assign op_b = id_ex_alu_src ? id_ex_imm : rs2_fwd;

  always_comb begin
    alu_res = '0;
    unique case (id_ex_alu_op)
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_SLL:   alu_res = op_a << op_b[4:0];
      OP_SRL:   alu_res = op_a >> op_b[4:0];
      OP_SRA:   alu_res = $signed(op_a) >>> op_b[4:0];
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}},
                           $signed(op_a) < $signed(op_b)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_PASSB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  ex_state_e       state;
  ex_state_e       state_nx;
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] product;

  mul_iter #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (id_ex_valid && id_ex_alu_op == OP_MUL && !flush_in) begin
          mul_start = rst_n;
          state_nx  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush_in)
          state_nx = ST_IDLE;
        else if (mul_done)
          state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (flush_in || !stall_in)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign ex_busy = rst_n &&
                   (mul_start || (state == ST_BUSY && !flush_in));
  assign hold_bubble = mul_start || (state == ST_BUSY);
  assign wb_res = (state == ST_DONE) ? product : alu_res;
`else
  assign ex_busy     = 1'b0;
  assign hold_bubble = 1'b0;
  assign wb_res      = alu_res;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r <= '0;
    end else if (flush_in) begin
      r <= '0;
    end else if (stall_in) begin
      r <= r;
    end else if (hold_bubble || !id_ex_valid) begin
      r <= '0;
    end else begin
      r.valid <= 1'b1;
      r.res   <= wb_res;
      r.sd    <= rs2_fwd;
      r.rd    <= id_ex_rd;
      r.rw    <= id_ex_regwrite;
      r.mtr   <= id_ex_memtoreg;
      r.mw    <= id_ex_memwrite;
    end
  end

  assign ex_mem_valid      = r.valid;
  assign ex_mem_alu_result = r.res;
  assign ex_mem_store_data = r.sd;
  assign ex_mem_rd         = r.rd;
  assign ex_mem_regwrite   = r.rw;
  assign ex_mem_memtoreg   = r.mtr;
  assign ex_mem_memwrite   = r.mw;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a transaction-level model.
// Build with EX_MUL_EN to exercise the iterative multiply.
module tb_ex_stage;

`ifdef EX_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  localparam int MUL_WAIT = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        flush_in;
  logic        id_ex_valid;
  logic [31:0] id_ex_rs1_data;
  logic [31:0] id_ex_rs2_data;
  logic [31:0] id_ex_imm;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alu_src;
  logic [4:0]  id_ex_rd;
  logic        id_ex_regwrite;
  logic        id_ex_memtoreg;
  logic        id_ex_memwrite;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic [31:0] mem_wb_data;
  logic        ex_busy;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_store_data;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regwrite;
  logic        ex_mem_memtoreg;
  logic        ex_mem_memwrite;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_in          (stall_in),
    .flush_in          (flush_in),
    .id_ex_valid       (id_ex_valid),
    .id_ex_rs1_data    (id_ex_rs1_data),
    .id_ex_rs2_data    (id_ex_rs2_data),
    .id_ex_imm         (id_ex_imm),
    .id_ex_alu_op      (id_ex_alu_op),
    .id_ex_alu_src     (id_ex_alu_src),
    .id_ex_rd          (id_ex_rd),
    .id_ex_regwrite    (id_ex_regwrite),
    .id_ex_memtoreg    (id_ex_memtoreg),
    .id_ex_memwrite    (id_ex_memwrite),
    .forward_a         (forward_a),
    .forward_b         (forward_b),
    .mem_wb_data       (mem_wb_data),
    .ex_busy           (ex_busy),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_regwrite   (ex_mem_regwrite),
    .ex_mem_memtoreg   (ex_mem_memtoreg),
    .ex_mem_memwrite   (ex_mem_memwrite)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // model of the EX/MEM contents and of an outstanding multiply
  logic        m_valid, m_rw, m_mtr, m_mw;
  logic [31:0] m_res, m_sd;
  logic [4:0]  m_rd;
  bit          pend = 1'b0;
  int          edges = 0;
  logic [31:0] prod;

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [63:0] ext;
    sh  = b % 32;
    ext = {{32{a[31]}}, a} >> sh;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return ext[31:0];
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel,
                                      input logic [31:0] rf);
    if (sel == 2'b10) return m_res;
    if (sel == 2'b01) return mem_wb_data;
    return rf;
  endfunction

  task automatic bubble();
    m_valid = 0; m_res = 0; m_sd = 0; m_rd = 0;
    m_rw = 0; m_mtr = 0; m_mw = 0;
  endtask

  task automatic tick();
    logic [31:0] a, b, sd, res;
    logic        start, exp_busy, v, st, fl, rs;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, mtr, mw;
    #1;
    a  = fwd(forward_a, id_ex_rs1_data);
    sd = fwd(forward_b, id_ex_rs2_data);
    b  = id_ex_alu_src ? id_ex_imm : sd;
    v  = id_ex_valid; st = stall_in; fl = flush_in; rs = rst_n;
    op = id_ex_alu_op; rd = id_ex_rd;
    rw = id_ex_regwrite; mtr = id_ex_memtoreg; mw = id_ex_memwrite;
    start = MUL_ON && !pend && v && op == 4'd11 && !fl;
    exp_busy = rs && (start || (pend && edges < MUL_WAIT && !fl));
    check("busy", {31'd0, ex_busy}, {31'd0, exp_busy});
    res = ref_alu(op, a, b);
    @(posedge clk);
    #1;
    if (!rs) begin
      bubble(); pend = 0;
    end else if (pend && fl) begin
      bubble(); pend = 0;
    end else if (pend && edges < MUL_WAIT) begin
      edges++;
      if (!st) bubble();
    end else if (pend) begin
      if (!st) begin
        pend = 0;
        if (v) begin
          m_valid = 1; m_res = prod; m_sd = sd; m_rd = rd;
          m_rw = rw; m_mtr = mtr; m_mw = mw;
        end else bubble();
      end
    end else if (fl) begin
      bubble();
    end else if (start) begin
      pend = 1; edges = 1; prod = a * b;
      if (!st) bubble();
    end else if (!st) begin
      if (v) begin
        m_valid = 1; m_res = res; m_sd = sd; m_rd = rd;
        m_rw = rw; m_mtr = mtr; m_mw = mw;
      end else bubble();
    end
    check("valid", {31'd0, ex_mem_valid}, {31'd0, m_valid});
    check("result", ex_mem_alu_result, m_res);
    check("store", ex_mem_store_data, m_sd);
    check("rd", {27'd0, ex_mem_rd}, {27'd0, m_rd});
    check("ctrl", {29'd0, ex_mem_regwrite, ex_mem_memtoreg, ex_mem_memwrite},
          {29'd0, m_rw, m_mtr, m_mw});
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm,
                        input logic src, input logic [1:0] fa,
                        input logic [1:0] fb);
    id_ex_valid = 1; id_ex_alu_op = op;
    id_ex_rs1_data = r1; id_ex_rs2_data = r2; id_ex_imm = imm;
    id_ex_alu_src = src; forward_a = fa; forward_b = fb;
    id_ex_rd = 5'($urandom); id_ex_regwrite = 1'($urandom);
    id_ex_memtoreg = 1'($urandom); id_ex_memwrite = 1'($urandom);
  endtask

  int nb, nbub;

  initial begin
    bubble();
    rst_n = 0; stall_in = 0; flush_in = 0; mem_wb_data = 0;
    set_op(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00);
    tick();
    tick();
    check("rst_valid", {31'd0, ex_mem_valid}, 32'd0);
    check("rst_result", ex_mem_alu_result, 32'd0);
    rst_n = 1;
    tick();
    check("add_5_7", ex_mem_alu_result, 32'd12);
    check("add_valid", {31'd0, ex_mem_valid}, 32'd1);

    set_op(4'd0, 32'd100, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00);
    tick();
    set_op(4'd1, 32'd1, 32'd3, 32'd0, 1'b0, 2'b10, 2'b00);
    tick();
    check("sub_fwd_exmem", ex_mem_alu_result, 32'd97);
    mem_wb_data = 32'd50;
    set_op(4'd1, 32'd1, 32'd3, 32'd0, 1'b0, 2'b01, 2'b00);
    tick();
    check("sub_fwd_memwb", ex_mem_alu_result, 32'd47);

    set_op(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 2'b00, 2'b00);
    tick();
    check("sra", ex_mem_alu_result, 32'hF800_0000);
    set_op(4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00);
    tick();
    check("sltu", ex_mem_alu_result, 32'd1);
    set_op(4'd8, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00);
    tick();
    check("slt", ex_mem_alu_result, 32'd0);
    set_op(4'd13, 32'd5, 32'd9, 32'd0, 1'b0, 2'b00, 2'b00);
    tick();
    check("op13_zero", ex_mem_alu_result, 32'd0);

    set_op(4'd0, 32'd9, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00);
    tick();
    set_op(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00);
    stall_in = 1;
    repeat (3) tick();
    check("stall_hold", ex_mem_alu_result, 32'd9);
    stall_in = 0;
    tick();
    check("stall_release", ex_mem_alu_result, 32'd2);
    stall_in = 1; flush_in = 1;
    tick();
    check("flush_stall", {31'd0, ex_mem_valid}, 32'd0);
    stall_in = 0; flush_in = 0;

    mem_wb_data = 32'd6;
    set_op(4'd11, 32'd0, 32'd7, 32'd0, 1'b0, 2'b01, 2'b00);
    if (MUL_ON) begin
      nb = 0; nbub = 0;
      for (int i = 0; i < MUL_WAIT; i++) begin
        #1;
        if (ex_busy) nb++;
        tick();
        if (!ex_mem_valid) nbub++;
        if (i == 1) mem_wb_data = 32'd99;
      end
      check("mul_busy_cycles", nb, MUL_WAIT);
      check("mul_bubbles", nbub, MUL_WAIT);
      tick();
      check("mul_result", ex_mem_alu_result, 32'd42);
      check("mul_valid", {31'd0, ex_mem_valid}, 32'd1);

      set_op(4'd11, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00);
      tick();
      repeat (10) tick();
      flush_in = 1;
      tick();
      flush_in = 0;
      check("mul_abort_busy", {31'd0, ex_busy}, 32'd0);
      check("mul_abort_bubble", {31'd0, ex_mem_valid}, 32'd0);
      set_op(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00);
      tick();
      check("add_after_abort", ex_mem_alu_result, 32'd5);
    end else begin
      tick();
      check("mul_off_zero", ex_mem_alu_result, 32'd0);
      check("mul_off_busy", {31'd0, ex_busy}, 32'd0);
    end

    for (int i = 0; i < 500; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd11 && $urandom_range(0, 3) != 0) op = 4'd0;
      set_op(op,
             ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
             ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
             $urandom, 1'($urandom), 2'($urandom), 2'($urandom));
      id_ex_valid = ($urandom_range(0, 7) != 0);
      stall_in    = ($urandom_range(0, 7) == 0);
      flush_in    = ($urandom_range(0, 15) == 0);
      mem_wb_data = $urandom;
      rst_n       = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
